// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares the single LC-3b memory port between instruction fetch and LDR/STR.
// Optional feature macro: LC3B_ARB_ROUND_ROBIN_EN (alternating tie-break instead of data-first).
module lc3b_mem_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_read,
   input  logic [15:0] i_address,
   output logic [15:0] i_rdata,
   output logic        i_resp,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [15:0] d_address,
   input  logic [15:0] d_wdata,
   input  logic [1:0]  d_byte_enable,
   output logic [15:0] d_rdata,
   output logic        d_resp,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   output logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_rdata,
   input  logic        mem_resp
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE_I = 2'd1,
      ST_SERVE_D = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_i_req;
   logic   w_d_req;
   logic   w_grant_d;

   assign w_i_req = i_read;
   assign w_d_req = d_read | d_write;

   // Read data is broadcast; the matching resp is what qualifies it.
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

`ifdef LC3B_ARB_ROUND_ROBIN_EN
   logic r_prio_d;
   logic w_prio_d_nxt;

   assign w_grant_d = w_d_req & (~w_i_req | r_prio_d);

   // Priority pointer: 1 favours data; moves only on completed grants.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prio_d <= 1'b1;
      end else begin
         r_prio_d <= w_prio_d_nxt;
      end
   end
`else
   assign w_grant_d = w_d_req;
`endif

   // Grant state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and port steering; IDLE outputs match the reset values.
   always_comb begin
      w_state_nxt     = r_state;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = 16'h0000;
      mem_wdata       = 16'h0000;
      mem_byte_enable = 2'b11;
      i_resp          = 1'b0;
      d_resp          = 1'b0;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
      w_prio_d_nxt    = r_prio_d;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_grant_d) begin
               w_state_nxt = ST_SERVE_D;
            end else if (w_i_req) begin
               w_state_nxt = ST_SERVE_I;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SERVE_I: begin
            mem_read    = i_read;
            mem_address = i_address;
            if (!w_i_req) begin
               w_state_nxt = ST_IDLE;
            end else if (mem_resp) begin
               i_resp      = 1'b1;
               w_state_nxt = ST_IDLE;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
               w_prio_d_nxt = 1'b1;
`endif
            end else begin
               w_state_nxt = ST_SERVE_I;
            end
         end
         ST_SERVE_D: begin
            // A simultaneous read and write is treated as a write.
            mem_read        = d_read & ~d_write;
            mem_write       = d_write;
            mem_address     = d_address;
            mem_wdata       = d_wdata;
            mem_byte_enable = d_byte_enable;
            if (!w_d_req) begin
               w_state_nxt = ST_IDLE;
            end else if (mem_resp) begin
               d_resp      = 1'b1;
               w_state_nxt = ST_IDLE;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
               w_prio_d_nxt = 1'b0;
`endif
            end else begin
               w_state_nxt = ST_SERVE_D;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: scoreboard of expected responses and grant order.
module tb_lc3b_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        i_read;
   logic [15:0] i_address;
   logic [15:0] i_rdata;
   logic        i_resp;
   logic        d_read;
   logic        d_write;
   logic [15:0] d_address;
   logic [15:0] d_wdata;
   logic [1:0]  d_byte_enable;
   logic [15:0] d_rdata;
   logic        d_resp;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_rdata;
   logic        mem_resp;

   typedef struct {
      bit          is_d;
      logic [15:0] data;
   } exp_t;

   exp_t sb_q[$];
   bit   grant_q[$];
   int   n_pass;
   int   n_total;

   lc3b_mem_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .i_read          (i_read),
      .i_address       (i_address),
      .i_rdata         (i_rdata),
      .i_resp          (i_resp),
      .d_read          (d_read),
      .d_write         (d_write),
      .d_address       (d_address),
      .d_wdata         (d_wdata),
      .d_byte_enable   (d_byte_enable),
      .d_rdata         (d_rdata),
      .d_resp          (d_resp),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      i_read        = 1'b0;
      i_address     = 16'h0000;
      d_read        = 1'b0;
      d_write       = 1'b0;
      d_address     = 16'h0000;
      d_wdata       = 16'h0000;
      d_byte_enable = 2'b00;
      mem_rdata     = 16'h0000;
      mem_resp      = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset    = 1'b1;
      mem_resp = 1'b1;
      @(negedge clk); #1;
      n_total += 7;
      if (mem_read !== 1'b0) $display("FAIL rst_mem_read: got %b want 0", mem_read); else n_pass++;
      if (mem_write !== 1'b0) $display("FAIL rst_mem_write: got %b want 0", mem_write); else n_pass++;
      if (mem_address !== 16'h0000) $display("FAIL rst_mem_address: got %h want 0000", mem_address); else n_pass++;
      if (mem_wdata !== 16'h0000) $display("FAIL rst_mem_wdata: got %h want 0000", mem_wdata); else n_pass++;
      if (mem_byte_enable !== 2'b11) $display("FAIL rst_byte_enable: got %b want 11", mem_byte_enable); else n_pass++;
      if (i_resp !== 1'b0) $display("FAIL rst_i_resp: got %b want 0", i_resp); else n_pass++;
      if (d_resp !== 1'b0) $display("FAIL rst_d_resp: got %b want 0", d_resp); else n_pass++;
      @(negedge clk);
      reset    = 1'b0;
      mem_resp = 1'b0;
      // Reset in the middle of a data write.
      @(negedge clk);
      d_write       = 1'b1;
      d_address     = 16'h0200;
      d_wdata       = 16'h5A5A;
      d_byte_enable = 2'b10;
      @(negedge clk); #1;
      n_total++;
      if (mem_write !== 1'b1) $display("FAIL midrst_write_before: got %b want 1", mem_write); else n_pass++;
      #2;
      reset    = 1'b1;
      mem_resp = 1'b1;
      #1;
      n_total += 3;
      if (mem_write !== 1'b0) $display("FAIL midrst_write_async: got %b want 0", mem_write); else n_pass++;
      if (mem_address !== 16'h0000) $display("FAIL midrst_address_async: got %h want 0000", mem_address); else n_pass++;
      if (d_resp !== 1'b0) $display("FAIL midrst_d_resp: got %b want 0", d_resp); else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      #1;
      n_total++;
      if (mem_write !== 1'b0) $display("FAIL midrst_idle_after: got %b want 0", mem_write); else n_pass++;
   endtask

   task automatic test_i_read();
      exp_t e;
      exp_t got;
      @(negedge clk);
      i_read    = 1'b1;
      i_address = 16'h0040;
      #1;
      n_total++;
      if (mem_read !== 1'b0) $display("FAIL i_grant_latency: got mem_read %b want 0", mem_read); else n_pass++;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(negedge clk);
         if (cyc == 3) begin
            mem_resp  = 1'b1;
            mem_rdata = 16'h1234;
            e.is_d = 1'b0;
            e.data = 16'h1234;
            sb_q.push_back(e);
         end
         #1;
         n_total += 3;
         if (mem_read !== 1'b1) $display("FAIL i_mem_read_c%0d: got %b want 1", cyc, mem_read); else n_pass++;
         if (mem_address !== 16'h0040) $display("FAIL i_mem_address_c%0d: got %h want 0040", cyc, mem_address); else n_pass++;
         if ({mem_write, mem_byte_enable} !== 3'b011) $display("FAIL i_write_be_c%0d: got %b want 011", cyc, {mem_write, mem_byte_enable}); else n_pass++;
         n_total++;
         if (cyc < 3) begin
            if ({i_resp, d_resp} !== 2'b00) $display("FAIL i_early_resp_c%0d: got %b want 00", cyc, {i_resp, d_resp}); else n_pass++;
         end else if ({i_resp, d_resp} !== 2'b10 || sb_q.size() == 0) begin
            $display("FAIL i_resp: got i/d resp %b want 10", {i_resp, d_resp});
         end else begin
            got = sb_q.pop_front();
            if (got.is_d !== 1'b0 || i_rdata !== got.data) $display("FAIL i_rdata: got %h want %h", i_rdata, got.data); else n_pass++;
         end
      end
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      n_total++;
      if ({mem_read, i_resp} !== 2'b00) $display("FAIL i_idle_bubble: got read/resp %b want 00", {mem_read, i_resp}); else n_pass++;
      idle_inputs();
   endtask

   task automatic test_d_write();
      exp_t e;
      exp_t got;
      @(negedge clk);
      d_write       = 1'b1;
      d_address     = 16'h0100;
      d_wdata       = 16'hBEEF;
      d_byte_enable = 2'b01;
      for (int cyc = 1; cyc <= 2; cyc++) begin
         @(negedge clk);
         if (cyc == 2) begin
            mem_resp  = 1'b1;
            mem_rdata = 16'hC0DE;
            e.is_d = 1'b1;
            e.data = 16'hC0DE;
            sb_q.push_back(e);
         end
         #1;
         n_total += 2;
         if ({mem_write, mem_read} !== 2'b10) $display("FAIL d_strobes_c%0d: got w/r %b want 10", cyc, {mem_write, mem_read}); else n_pass++;
         if ({mem_address, mem_wdata, mem_byte_enable} !== {16'h0100, 16'hBEEF, 2'b01})
            $display("FAIL d_fields_c%0d: got %h %h %b want 0100 beef 01", cyc, mem_address, mem_wdata, mem_byte_enable);
         else n_pass++;
      end
      n_total++;
      if ({i_resp, d_resp} !== 2'b01 || sb_q.size() == 0) begin
         $display("FAIL d_resp: got i/d resp %b want 01", {i_resp, d_resp});
      end else begin
         got = sb_q.pop_front();
         if (got.is_d !== 1'b1 || d_rdata !== got.data) $display("FAIL d_rdata: got %h want %h", d_rdata, got.data); else n_pass++;
      end
      // Read and write together behave as a write.
      @(negedge clk);
      mem_resp  = 1'b0;
      d_read    = 1'b1;
      d_address = 16'h0102;
      #1;
      n_total++;
      if (mem_write !== 1'b0) $display("FAIL d_idle_bubble: got %b want 0", mem_write); else n_pass++;
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = 16'h0F0F;
      e.is_d = 1'b1;
      e.data = 16'h0F0F;
      sb_q.push_back(e);
      #1;
      n_total += 2;
      if ({mem_write, mem_read} !== 2'b10) $display("FAIL rw_as_write: got w/r %b want 10", {mem_write, mem_read}); else n_pass++;
      if ({i_resp, d_resp} !== 2'b01 || sb_q.size() == 0) begin
         $display("FAIL rw_resp: got i/d resp %b want 01", {i_resp, d_resp});
      end else begin
         got = sb_q.pop_front();
         if (d_rdata !== got.data) $display("FAIL rw_rdata: got %h want %h", d_rdata, got.data); else n_pass++;
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_tie_priority();
      int grants;
      bit prev_strobe;
      bit want_d;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      i_read    = 1'b1;
      d_read    = 1'b1;
      i_address = 16'h0AAA;
      d_address = 16'h0DDD;
      for (int k = 0; k < 6; k++) begin
`ifdef LC3B_ARB_ROUND_ROBIN_EN
         grant_q.push_back(k % 2 == 0);
`else
         grant_q.push_back(1'b1);
`endif
      end
      grants      = 0;
      prev_strobe = 1'b0;
      for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
         @(negedge clk);
         mem_resp = 1'b0;
         #1;
         if (mem_read || mem_write) begin
            want_d = grant_q.pop_front();
            n_total += 3;
            if (prev_strobe !== 1'b0) $display("FAIL tie_bubble_g%0d: strobe in consecutive cycles", grants); else n_pass++;
            if (mem_address !== (want_d ? 16'h0DDD : 16'h0AAA))
               $display("FAIL tie_grant_g%0d: got address %h want %h", grants, mem_address, want_d ? 16'h0DDD : 16'h0AAA);
            else n_pass++;
            mem_resp  = 1'b1;
            mem_rdata = 16'h7000 + 16'(grants);
            #1;
            if ({i_resp, d_resp} !== (want_d ? 2'b01 : 2'b10))
               $display("FAIL tie_resp_g%0d: got i/d resp %b want %b", grants, {i_resp, d_resp}, want_d ? 2'b01 : 2'b10);
            else n_pass++;
            grants++;
            prev_strobe = 1'b1;
         end else begin
            prev_strobe = 1'b0;
         end
      end
      n_total++;
      if (grants != 6) $display("FAIL tie_timeout: got %0d grants want 6", grants); else n_pass++;
      @(negedge clk);
      idle_inputs();
      grant_q.delete();
   endtask

   task automatic test_abort();
      @(negedge clk);
      d_read    = 1'b1;
      d_address = 16'h0300;
      for (int cyc = 1; cyc <= 2; cyc++) begin
         @(negedge clk); #1;
         n_total++;
         if (mem_read !== 1'b1) $display("FAIL abort_read_c%0d: got %b want 1", cyc, mem_read); else n_pass++;
      end
      @(negedge clk);
      d_read = 1'b0;
      #1;
      n_total++;
      if ({mem_read, d_resp} !== 2'b00) $display("FAIL abort_drop: got read/resp %b want 00", {mem_read, d_resp}); else n_pass++;
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      n_total++;
      if ({mem_read, i_resp, d_resp} !== 3'b000) $display("FAIL abort_late_resp: got read/i/d %b want 000", {mem_read, i_resp, d_resp}); else n_pass++;
      @(negedge clk);
      idle_inputs();
      n_total++;
      if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size()); else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b1;
      idle_inputs();
      test_reset();
      test_i_read();
      test_d_write();
      test_tie_priority();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
